exec_writeback_stage: RTL and testbench

- Consumer of the decode-stage pipeline register outputs (wren, writeAd, input select, valid). Two-stage execute/write-back pipe driving the 8-entry register-file write port.
- Selects ALU result or external input data. For input instructions, waits on an external-data valid/ready handshake.
- Provides EX/WB operand forwarding and a stall back to decode.

---
 rtl/exec_writeback_stage_pkg.sv | 23 ++
 rtl/exec_writeback_stage_fwd_select.sv | 34 +++
 rtl/exec_writeback_stage.sv | 127 ++++++++++++
 tb/tb_exec_writeback_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_writeback_stage_pkg.sv
// Shared widths, FSM state and stage-entry payload for the execute/write-back pipe.
package exec_writeback_stage_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;

  typedef enum logic {
    RUN      = 1'b0,
    WAIT_EXT = 1'b1
  } state_e;

  // One pipeline entry; 'inp' marks an external-input instruction,
  // 'filled' says the data field holds the final result.
  typedef struct packed {
    logic              valid;
    logic              wren;
    logic              inp;
    logic              filled;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/exec_writeback_stage_fwd_select.sv
// Forward select for one operand: compares a source address against the EX
// and WB entries, EX taking priority.
//   src        operand address being read in decode
//   ex, wb     current EX / WB entries
//   fwd_valid  a usable forward exists
//   fwd_data   forwarded value (0 when fwd_valid is low)
module exec_writeback_stage_fwd_select
  import exec_writeback_stage_pkg::*;
(
  input  logic [ADDR_W-1:0] src,
  input  stage_t            ex,
  input  stage_t            wb,
  output logic              fwd_valid,
  output logic [DATA_W-1:0] fwd_data
);

  // Fields carried in the entry but irrelevant to forwarding.
  logic unused_fields;
  assign unused_fields = ex.inp ^ wb.inp ^ wb.filled;

  // EX wins over WB since it is the younger write to the same register.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_data  = '0;
    if (ex.valid && ex.wren && ex.filled && (ex.addr == src)) begin
      fwd_valid = 1'b1;
      fwd_data  = ex.data;
    end else if (wb.valid && wb.wren && (wb.addr == src)) begin
      fwd_valid = 1'b1;
      fwd_data  = wb.data;
    end
  end

endmodule

// File: rtl/exec_writeback_stage.sv
// Execute / write-back pipe feeding the 8-entry register-file write port.
// Selects ALU result or external input data (valid/ready handshake), provides
// EX/WB operand forwarding and a stall back to decode.
//   CLK, RST_N                       clock, async active-low reset
//   VALID_IN, wren_IN, writeAd_IN,
//   input_IN, ALU_RES_IN             decode register outputs
//   EXT_DATA_IN, EXT_VALID_IN,
//   EXT_READY_OUT                    external input handshake
//   FLUSH_IN                         kill younger instructions
//   SRCA_IN, SRCB_IN                 operand addresses read in decode
//   RF_WE_OUT, RF_WA_OUT, RF_WD_OUT  register-file write port (registered)
//   FWD{A,B}_VALID_OUT, FWD{A,B}_OUT forwarding results
//   STALL_OUT                        decode must hold its register
module exec_writeback_stage
  import exec_writeback_stage_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              VALID_IN,
  input  logic              wren_IN,
  input  logic [ADDR_W-1:0] writeAd_IN,
  input  logic              input_IN,
  input  logic [DATA_W-1:0] ALU_RES_IN,
  input  logic [DATA_W-1:0] EXT_DATA_IN,
  input  logic              EXT_VALID_IN,
  output logic              EXT_READY_OUT,
  input  logic              FLUSH_IN,
  input  logic [ADDR_W-1:0] SRCA_IN,
  input  logic [ADDR_W-1:0] SRCB_IN,
  output logic              RF_WE_OUT,
  output logic [ADDR_W-1:0] RF_WA_OUT,
  output logic [DATA_W-1:0] RF_WD_OUT,
  output logic              FWDA_VALID_OUT,
  output logic              FWDB_VALID_OUT,
  output logic [DATA_W-1:0] FWDA_OUT,
  output logic [DATA_W-1:0] FWDB_OUT,
  output logic              STALL_OUT
);

  state_e state_q, state_d;
  stage_t ex_q, ex_d;
  stage_t wb_q, wb_d;
  logic   hazard;
  logic   capture;

  // State and pipeline registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RUN;
      ex_q    <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      wb_q    <= wb_d;
    end
  end

  // Next state, EX/WB advance, stall and external-ready generation.
  always_comb begin
    state_d       = state_q;
    ex_d          = ex_q;
    wb_d          = '0;
    EXT_READY_OUT = 1'b0;

    hazard    = ex_q.valid && ex_q.inp && !ex_q.filled &&
                ((SRCA_IN == ex_q.addr) || (SRCB_IN == ex_q.addr));
    STALL_OUT = (state_q == WAIT_EXT) || hazard;
    capture   = VALID_IN && !STALL_OUT && !FLUSH_IN;

    // A flushed EX entry is killed rather than retired; WB always completes.
    if (ex_q.valid && (state_q == RUN) && !FLUSH_IN) begin
      wb_d = ex_q;
    end

    if (FLUSH_IN) begin
      ex_d.valid = 1'b0;
      state_d    = RUN;
    end else begin
      case (state_q)
        WAIT_EXT: begin
          EXT_READY_OUT = 1'b1;
          if (EXT_VALID_IN) begin
            ex_d.data   = EXT_DATA_IN;
            ex_d.filled = 1'b1;
            state_d     = RUN;
          end
        end
        default: begin
          ex_d.valid = capture;
          if (capture) begin
            ex_d.wren   = wren_IN;
            ex_d.inp    = input_IN;
            // An input op that does not write is a no-op: nothing to fill.
            ex_d.filled = !(input_IN && wren_IN);
            ex_d.addr   = writeAd_IN;
            ex_d.data   = input_IN ? '0 : ALU_RES_IN;
            if (input_IN && wren_IN) begin
              state_d = WAIT_EXT;
            end
          end
        end
      endcase
    end
  end

  assign RF_WE_OUT = wb_q.valid & wb_q.wren;
  assign RF_WA_OUT = wb_q.addr;
  assign RF_WD_OUT = wb_q.data;

  exec_writeback_stage_fwd_select u_fwd_a (
    .src       (SRCA_IN),
    .ex        (ex_q),
    .wb        (wb_q),
    .fwd_valid (FWDA_VALID_OUT),
    .fwd_data  (FWDA_OUT)
  );

  exec_writeback_stage_fwd_select u_fwd_b (
    .src       (SRCB_IN),
    .ex        (ex_q),
    .wb        (wb_q),
    .fwd_valid (FWDB_VALID_OUT),
    .fwd_data  (FWDB_OUT)
  );

endmodule

// File: tb/tb_exec_writeback_stage.sv
`timescale 1ns/1ps
module tb_exec_writeback_stage;

  logic        CLK;
  logic        RST_N;
  logic        VALID_IN;
  logic        wren_IN;
  logic [2:0]  writeAd_IN;
  logic        input_IN;
  logic [15:0] ALU_RES_IN;
  logic [15:0] EXT_DATA_IN;
  logic        EXT_VALID_IN;
  logic        EXT_READY_OUT;
  logic        FLUSH_IN;
  logic [2:0]  SRCA_IN;
  logic [2:0]  SRCB_IN;
  logic        RF_WE_OUT;
  logic [2:0]  RF_WA_OUT;
  logic [15:0] RF_WD_OUT;
  logic        FWDA_VALID_OUT;
  logic        FWDB_VALID_OUT;
  logic [15:0] FWDA_OUT;
  logic [15:0] FWDB_OUT;
  logic        STALL_OUT;

  int n_checks = 0;
  int n_errors = 0;

  // Expected RF writes: {addr, data}
  logic [18:0] sb[$];

  exec_writeback_stage dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .VALID_IN       (VALID_IN),
    .wren_IN        (wren_IN),
    .writeAd_IN     (writeAd_IN),
    .input_IN       (input_IN),
    .ALU_RES_IN     (ALU_RES_IN),
    .EXT_DATA_IN    (EXT_DATA_IN),
    .EXT_VALID_IN   (EXT_VALID_IN),
    .EXT_READY_OUT  (EXT_READY_OUT),
    .FLUSH_IN       (FLUSH_IN),
    .SRCA_IN        (SRCA_IN),
    .SRCB_IN        (SRCB_IN),
    .RF_WE_OUT      (RF_WE_OUT),
    .RF_WA_OUT      (RF_WA_OUT),
    .RF_WD_OUT      (RF_WD_OUT),
    .FWDA_VALID_OUT (FWDA_VALID_OUT),
    .FWDB_VALID_OUT (FWDB_VALID_OUT),
    .FWDA_OUT       (FWDA_OUT),
    .FWDB_OUT       (FWDB_OUT),
    .STALL_OUT      (STALL_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [2:0] ad, input logic inp, input logic [15:0] alu);
    VALID_IN   = 1'b1;
    wren_IN    = wr;
    writeAd_IN = ad;
    input_IN   = inp;
    ALU_RES_IN = alu;
  endtask

  task automatic idle(input int n);
    VALID_IN = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: every RF write must match the oldest expected write.
  always @(negedge CLK) begin
    if (RF_WE_OUT === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rf_unexpected: got write r%0d=%0h expected no write at %0t",
                 RF_WA_OUT, RF_WD_OUT, $time);
      end else begin
        logic [18:0] e;
        e = sb.pop_front();
        chk("rf_wa", 32'(RF_WA_OUT), 32'(e[18:16]));
        chk("rf_wd", 32'(RF_WD_OUT), 32'(e[15:0]));
      end
    end
  end

  initial begin
    RST_N = 1'b0; VALID_IN = 1'b0; wren_IN = 1'b0; writeAd_IN = 3'd0;
    input_IN = 1'b0; ALU_RES_IN = 16'h0; EXT_DATA_IN = 16'h0; EXT_VALID_IN = 1'b0;
    FLUSH_IN = 1'b0; SRCA_IN = 3'd0; SRCB_IN = 3'd0;
    #2;
    chk("rst_we", 32'(RF_WE_OUT), 32'd0);
    chk("rst_stall", 32'(STALL_OUT), 32'd0);
    chk("rst_ready", 32'(EXT_READY_OUT), 32'd0);
    chk("rst_fwda_v", 32'(FWDA_VALID_OUT), 32'd0);
    tick();
    RST_N = 1'b1;
    idle(2);

    // ALU write r5=1234, visible in the cycle after the second edge.
    issue(1'b1, 3'd5, 1'b0, 16'h1234);
    sb.push_back({3'd5, 16'h1234});
    chk("alu_stall0", 32'(STALL_OUT), 32'd0);
    tick();
    VALID_IN = 1'b0;
    chk("alu_stall1", 32'(STALL_OUT), 32'd0);
    chk("alu_we_early", 32'(RF_WE_OUT), 32'd0);
    tick();
    chk("alu_lat", 32'(RF_WE_OUT), 32'd1);
    idle(2);

    // Input op without wren is a no-op: no wait, no write.
    issue(1'b0, 3'd0, 1'b1, 16'h0);
    tick();
    VALID_IN = 1'b0;
    chk("noop_stall", 32'(STALL_OUT), 32'd0);
    chk("noop_ready", 32'(EXT_READY_OUT), 32'd0);
    idle(3);

    // External input to r3, data arrives after 3 idle cycles.
    issue(1'b1, 3'd3, 1'b1, 16'hDEAD);
    sb.push_back({3'd3, 16'hBEEF});
    tick();
    VALID_IN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ext_stall", 32'(STALL_OUT), 32'd1);
      chk("ext_ready", 32'(EXT_READY_OUT), 32'd1);
      chk("ext_we_wait", 32'(RF_WE_OUT), 32'd0);
      EXT_VALID_IN = (i == 3);
      EXT_DATA_IN  = 16'hBEEF;
      tick();
    end
    EXT_VALID_IN = 1'b0;
    chk("ext_stall_done", 32'(STALL_OUT), 32'd0);
    chk("ext_ready_done", 32'(EXT_READY_OUT), 32'd0);
    tick();
    chk("ext_lat", 32'(RF_WE_OUT), 32'd1);
    idle(3);

    // Forwarding: r2=0011 then r2=0022 back-to-back.
    SRCA_IN = 3'd2;
    issue(1'b1, 3'd2, 1'b0, 16'h0011);
    sb.push_back({3'd2, 16'h0011});
    tick();
    issue(1'b1, 3'd2, 1'b0, 16'h0022);
    sb.push_back({3'd2, 16'h0022});
    chk("fwd1_v", 32'(FWDA_VALID_OUT), 32'd1);
    chk("fwd1_d", 32'(FWDA_OUT), 32'h0011);
    tick();
    VALID_IN = 1'b0;
    chk("fwd2_v", 32'(FWDA_VALID_OUT), 32'd1);
    chk("fwd2_d", 32'(FWDA_OUT), 32'h0022);
    tick();
    chk("fwd3_wb_d", 32'(FWDA_OUT), 32'h0022);
    idle(3);
    SRCA_IN = 3'd0;

    // Hazard: pending input op to r4 read as operand B; younger op held upstream.
    SRCB_IN = 3'd4;
    issue(1'b1, 3'd4, 1'b1, 16'h0);
    sb.push_back({3'd4, 16'h5A5A});
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("haz_stall", 32'(STALL_OUT), 32'd1);
      chk("haz_fwdb_v", 32'(FWDB_VALID_OUT), 32'd0);
      issue(1'b1, 3'd7, 1'b0, 16'h7777);
      EXT_VALID_IN = (i == 1);
      EXT_DATA_IN  = 16'h5A5A;
      tick();
    end
    VALID_IN = 1'b0;
    EXT_VALID_IN = 1'b0;
    chk("haz_stall_done", 32'(STALL_OUT), 32'd0);
    chk("haz_fwdb_v1", 32'(FWDB_VALID_OUT), 32'd1);
    chk("haz_fwdb_d", 32'(FWDB_OUT), 32'h5A5A);
    idle(3);
    SRCB_IN = 3'd0;

    // Flush during WAIT_EXT with data offered; older r1 write still retires.
    issue(1'b1, 3'd1, 1'b0, 16'h0101);
    sb.push_back({3'd1, 16'h0101});
    tick();
    issue(1'b1, 3'd6, 1'b1, 16'h0);
    tick();
    VALID_IN = 1'b0;
    chk("fl_stall_pre", 32'(STALL_OUT), 32'd1);
    chk("fl_ready_pre", 32'(EXT_READY_OUT), 32'd1);
    FLUSH_IN = 1'b1;
    EXT_VALID_IN = 1'b1;
    EXT_DATA_IN = 16'hFFFF;
    #1;
    chk("fl_ready_forced", 32'(EXT_READY_OUT), 32'd0);
    tick();
    FLUSH_IN = 1'b0;
    EXT_VALID_IN = 1'b0;
    chk("fl_stall_post", 32'(STALL_OUT), 32'd0);
    chk("fl_ready_post", 32'(EXT_READY_OUT), 32'd0);
    idle(4);

    // Async reset mid-WAIT_EXT, between clock edges.
    SRCA_IN = 3'd5;
    issue(1'b1, 3'd5, 1'b1, 16'h0);
    tick();
    VALID_IN = 1'b0;
    chk("ar_stall_pre", 32'(STALL_OUT), 32'd1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("ar_we", 32'(RF_WE_OUT), 32'd0);
    chk("ar_wa", 32'(RF_WA_OUT), 32'd0);
    chk("ar_wd", 32'(RF_WD_OUT), 32'd0);
    chk("ar_stall", 32'(STALL_OUT), 32'd0);
    chk("ar_ready", 32'(EXT_READY_OUT), 32'd0);
    chk("ar_fwda_v", 32'(FWDA_VALID_OUT), 32'd0);
    chk("ar_fwda_d", 32'(FWDA_OUT), 32'd0);
    EXT_VALID_IN = 1'b1;
    EXT_DATA_IN = 16'h1111;
    #2;
    RST_N = 1'b1;
    tick();
    chk("ar_ready_post", 32'(EXT_READY_OUT), 32'd0);
    tick();
    EXT_VALID_IN = 1'b0;
    idle(4);
    SRCA_IN = 3'd0;

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
